// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement,
// retiring BPC multiplier bits per cycle. Sign-magnitude internally, negated at the end.
module seq_mult #(
  parameter int WIDTH = 24,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  localparam int N  = WIDTH / BPC;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || WIDTH > 64 || !(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0)
      begin : g_bad_params
        $error("seq_mult: illegal WIDTH/BPC combination");
      end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]          mcand_sh, acc, psum;
  logic [WIDTH-1:0]       mplier, mag1, mag2;
  logic [CW-1:0]          cnt;
  logic                   sign;
  logic [BPC-1:0][PW-1:0] pp;

  // Most-negative operand negates to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign mag1 = (signed_mode && num1[WIDTH-1]) ? -num1 : num1;
  assign mag2 = (signed_mode && num2[WIDTH-1]) ? -num2 : num2;

  // Multiplicand is pre-shifted each cycle, so partial products need only a fixed per-bit shift.
  for (genvar j = 0; j < BPC; j++) begin : g_pp
    assign pp[j] = mplier[j] ? (mcand_sh << j) : '0;
  end

  always_comb begin
    psum = '0;
    for (int j = 0; j < BPC; j++) psum = psum + pp[j];
  end

  assign ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt == CW'(N - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand_sh <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mcand_sh <= {{WIDTH{1'b0}}, mag1};
          mplier   <= mag2;
          sign     <= signed_mode & (num1[WIDTH-1] ^ num2[WIDTH-1]);
          acc      <= '0;
          cnt      <= '0;
        end
        RUN: begin
          acc      <= acc + psum;
          mcand_sh <= mcand_sh << BPC;
          mplier   <= mplier >> BPC;
          cnt      <= cnt + CW'(1);
        end
        FINISH: begin
          result <= sign ? -acc : acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: three instances (6b/BPC1, 24b/BPC2, 24b/BPC4),
// expected products and acceptance cycles queued by stimulus, checked on done.
module tb_seq_mult;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    logic [47:0] res;
    int          acc;
  } exp_t;
  exp_t q [3][$];
  exp_t e;

  logic        st [3];
  logic        sm [3];
  logic [23:0] n1 [3];
  logic [23:0] n2 [3];
  logic        rdy [3];
  logic        dn [3];
  logic        prev [3];
  logic [47:0] r [3];
  logic [11:0] res6;
  logic [47:0] res24a, res24b;
  int          lat [3] = '{7, 13, 7};

  assign r[0] = {36'b0, res6};
  assign r[1] = res24a;
  assign r[2] = res24b;

  seq_mult #(.WIDTH(6), .BPC(1)) u_w6 (
    .clk(clk), .rstn(rstn), .start(st[0]), .signed_mode(sm[0]),
    .num1(n1[0][5:0]), .num2(n2[0][5:0]), .ready(rdy[0]), .done(dn[0]), .result(res6));
  seq_mult #(.WIDTH(24), .BPC(2)) u_w24b2 (
    .clk(clk), .rstn(rstn), .start(st[1]), .signed_mode(sm[1]),
    .num1(n1[1]), .num2(n2[1]), .ready(rdy[1]), .done(dn[1]), .result(res24a));
  seq_mult #(.WIDTH(24), .BPC(4)) u_w24b4 (
    .clk(clk), .rstn(rstn), .start(st[2]), .signed_mode(sm[2]),
    .num1(n1[2]), .num2(n2[2]), .ready(rdy[2]), .done(dn[2]), .result(res24b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every done must match the oldest queued expectation and its latency.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) begin
        if (q[k].size() == 0) fail($sformatf("dut%0d unexpected done", k));
        else begin
          e = q[k].pop_front();
          chk($sformatf("dut%0d result", k), {16'b0, r[k]}, {16'b0, e.res});
          chk($sformatf("dut%0d latency", k), 64'(cyc - e.acc), 64'(lat[k]));
        end
        chk($sformatf("dut%0d ready with done", k), {63'b0, rdy[k]}, 64'd1);
        if (prev[k]) fail($sformatf("dut%0d done high two cycles", k));
      end
      prev[k] = dn[k];
    end
  end

  task automatic issue(input int k, input logic [23:0] a, input logic [23:0] b, input logic sg,
                       input logic [47:0] expv, input bit push, output int acc);
    int t = 0;
    @(negedge clk);
    while (!rdy[k] && t < 200) begin @(negedge clk); t++; end
    if (!rdy[k]) fail($sformatf("dut%0d ready timeout", k));
    n1[k] = a; n2[k] = b; sm[k] = sg; st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    acc = cyc;
    if (push) q[k].push_back('{expv, acc});
  endtask

  task automatic drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 500) begin
      @(negedge clk); t++;
    end
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) fail("drain timeout, done missing");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int t = 0;
    while (cyc < target && t < 100) begin @(negedge clk); t++; end
  endtask

  int a;

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; sm[k] = 1'b0; n1[k] = '0; n2[k] = '0; prev[k] = 1'b0;
    end
    rstn = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset ready", k), {63'b0, rdy[k]}, 64'd1);
      chk($sformatf("dut%0d reset done", k), {63'b0, dn[k]}, 64'd0);
      chk($sformatf("dut%0d reset result", k), {16'b0, r[k]}, 64'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // 6-bit unsigned and signed corners
    issue(0, 24'd63, 24'd63, 1'b0, 48'hF81, 1'b1, a);
    drain();
    issue(0, 24'h3B, 24'd7, 1'b1, 48'hFDD, 1'b1, a);   // -5 * 7
    drain();
    issue(0, 24'h20, 24'h20, 1'b1, 48'h400, 1'b1, a);  // -32 * -32
    drain();
    issue(0, 24'h00, 24'h20, 1'b1, 48'h000, 1'b1, a);  // 0 * -32
    drain();

    // 24-bit, BPC=2 and BPC=4
    issue(1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1, a);
    issue(2, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1, a);
    drain();
    issue(1, 24'hFFFFFF, 24'd5, 1'b1, 48'hFFFFFFFFFFFB, 1'b1, a);   // -1 * 5
    issue(2, 24'h800000, 24'h800000, 1'b1, 48'h400000000000, 1'b1, a);
    drain();
    issue(1, 24'h123456, 24'h10, 1'b0, 48'h000001234560, 1'b1, a);
    drain();

    // start while busy is ignored, operand changes do not leak in
    issue(0, 24'd3, 24'd4, 1'b0, 48'd12, 1'b1, a);
    wait_cyc(a + 1);
    st[0] = 1'b1; n1[0] = 24'd5; n2[0] = 24'd5;
    @(negedge clk);
    st[0] = 1'b0; n1[0] = 24'd7; n2[0] = 24'd9;
    drain();

    // reset mid-operation: no done, result cleared
    issue(0, 24'd63, 24'd63, 1'b0, 48'd0, 1'b0, a);
    wait_cyc(a + 3);
    rstn = 1'b0;
    #1;
    chk("abort done low", {63'b0, dn[0]}, 64'd0);
    chk("abort result cleared", {16'b0, r[0]}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("abort ready after release", {63'b0, rdy[0]}, 64'd1);
    repeat (12) @(negedge clk);
    issue(0, 24'd2, 24'd3, 1'b0, 48'd6, 1'b1, a);
    drain();

    // back-to-back with start held high
    @(negedge clk);
    n1[0] = 24'd10; n2[0] = 24'd10; sm[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    q[0].push_back('{48'd100, a});
    q[0].push_back('{48'd1, a + 8});
    n1[0] = 24'h3F; n2[0] = 24'h3F; sm[0] = 1'b1;
    wait_cyc(a + 8);
    st[0] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised iterative shift-add multiplier for the FPU datapath, replacing the fixed 6-bit unit. Multiplies two WIDTH-bit operands, unsigned or two's complement (selected per operation), retiring BPC multiplier bits per cycle. Operands are captured on a start/ready handshake, and the 2*WIDTH-bit product is held until the next operation completes. The mantissa path instantiates it with WIDTH=24 to form the raw significand product.

## Interface
- WIDTH, 24, operand width in bits; legal values are 2 to 64.
- BPC, 1, multiplier bits retired per cycle; legal values are 1, 2 or 4, and WIDTH % BPC must be 0. An illegal value is an elaboration error.
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge only when ready=1.
- signed_mode  in  1  1 = operands and product are two's complement; sampled with start.
- num1  in  WIDTH  multiplicand; sampled with start.
- num2  in  WIDTH  multiplier; sampled with start.
- ready  out  1  1 when idle and able to accept start.
- done  out  1  one-cycle pulse; result is updated on the same edge.
- result  out  2*WIDTH  product; holds its value until the next done.

## Operation
- Let N = WIDTH/BPC.
- State machine:
  - IDLE -> RUN on start&&ready.
  - RUN -> RUN while the iteration count is below N-1; RUN -> FINISH after iteration N-1.
  - FINISH -> IDLE unconditionally.
- IDLE: ready=1. On acceptance, capture operands and mode, then clear the accumulator and iteration counter.
- Capture in signed mode: store |num1| and |num2| as WIDTH-bit unsigned magnitudes, and store sign = num1[WIDTH-1]^num2[WIDTH-1].
- Capture in unsigned mode: store the operands as-is, with sign = 0.
- Most-negative operand: its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits and needs no special case.
- RUN, iteration i: acc += (mcand * mplier[BPC-1:0]) << (i*BPC), computed at 2*WIDTH bits with no truncation. Then mplier is shifted right by BPC. Internal structure is free; only the final sum is specified.
- FINISH: result <= sign ? -acc : acc (2*WIDTH-bit two's complement), done <= 1.
- Signed products always fit: (-2^(W-1))^2 = 2^(2W-2) < 2^(2W-1).
- start while ready=0 is ignored and does not queue. In-flight operands are unaffected by input changes.
- rstn low, including mid-operation, has immediate effect:
  - state goes to IDLE;
  - result, acc, counter, done and sign are cleared;
  - ready=1 once rstn is released.
  - The aborted operation produces no done.

## Timing
- Reset values: ready=1, done=0, result=0.
- Start accepted at edge 0:
  - ready=0 after edge 0;
  - RUN occupies edges 1..N;
  - FINISH at edge N+1 updates result and sets done=1 and ready=1 for one cycle.
- Latency is N+1 edges from acceptance to done, independent of operand values. No early exit.
- Back-to-back: start held high during the done cycle is accepted at edge N+2, giving a throughput of one product per N+2 cycles.
- done is deasserted after one cycle unless a new FINISH occurs. Since that takes at least N+2 edges, done is never high for two consecutive cycles.
- result is stable from the done edge until the next FINISH edge. It is unaffected by start, the RUN cycles, or operand changes.

## Test plan
- WIDTH=6, BPC=1, unsigned, num1=63, num2=63, start for one cycle -> done exactly 7 edges after acceptance, result=12'hF81, ready high again with done.
- WIDTH=6, BPC=1, signed:
  - -5 * 7 -> result=12'hFDD;
  - -32 * -32 -> result=12'h400;
  - 0 * -32 -> result=12'h000 (no negative zero).
- WIDTH=24, BPC=2, unsigned, 24'hFFFFFF * 24'hFFFFFF -> result=48'hFFFFFE000001, done 13 edges after acceptance. Repeat with BPC=4 -> same result, latency 7.
- WIDTH=6, BPC=1: start 3*4, then at edge 2 pulse start with 5*5 and change num1/num2 -> the second start is ignored, result=12, exactly one done pulse.
- WIDTH=6, BPC=1: start 63*63, assert rstn low at edge 3 -> result=0, done=0, ready=1 after release, no done afterwards. A fresh 2*3 then gives result=6 after 7 edges.
- Back-to-back: hold start high with alternating operands (unsigned 10*10, then signed -1*-1) -> results 100 then 1, done pulses 8 edges apart, never two consecutive done cycles.
